// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//   End-of-test checker for riscv-tests runs. Snoops the regfile write port,
//   shadows the test-number and pass-flag registers, detects the done write,
//   waits a drain window and then reports PASS/FAIL (and optionally TIMEOUT).
//
// Optional feature: define TEST_MON_TIMEOUT_EN to enable the RUN-state watchdog.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-low reset
//   we_i           in   regfile write enable (snooped)
//   waddr_i        in   regfile write address
//   wdata_i        in   regfile write data
//   done_o         out  evaluation complete (sticky until reset)
//   pass_o         out  test passed (valid with done_o)
//   fail_o         out  test failed or timed out (valid with done_o)
//   timeout_o      out  watchdog expired (valid with done_o)
//   fail_testnum_o out  shadowed test number captured at evaluation
//   cycle_cnt_o    out  cycles spent in RUN, saturating
module riscv_test_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned PASS_REG       = 27,
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  fail_testnum_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [7:0]       r_drain_cnt, w_drain_cnt_d;
  logic [CNT_W-1:0] r_cycle_cnt, w_cycle_cnt_d;
  logic [XLEN-1:0]  r_testnum_sh, w_testnum_sh_d;
  logic [XLEN-1:0]  r_pass_sh, w_pass_sh_d;
  logic             r_done, w_done_d;
  logic             r_pass, w_pass_d;
  logic             r_fail, w_fail_d;
  logic [XLEN-1:0]  r_fail_tn, w_fail_tn_d;

  logic w_wr_valid;
  logic w_done_wr;

  // The done flag needs no shadow: only the triggering write itself matters.
  assign w_wr_valid = we_i && (waddr_i != 5'd0) && (r_state != StDone);
  assign w_done_wr  = w_wr_valid && (waddr_i == 5'(DONE_REG)) && (wdata_i == XLEN'(1));

  // Next shadow values double as the forwarded values used at evaluation.
  always_comb begin
    w_testnum_sh_d = r_testnum_sh;
    w_pass_sh_d    = r_pass_sh;
    if (w_wr_valid && (waddr_i == 5'(TESTNUM_REG))) w_testnum_sh_d = wdata_i;
    if (w_wr_valid && (waddr_i == 5'(PASS_REG)))    w_pass_sh_d    = wdata_i;
  end

`ifdef TEST_MON_TIMEOUT_EN
  logic r_timeout, w_timeout_d;
  logic w_wdog_hit;
  assign w_wdog_hit = (r_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o  = r_timeout;
`else
  logic [31:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_drain_cnt_d = r_drain_cnt;
    w_cycle_cnt_d = r_cycle_cnt;
    w_done_d      = r_done;
    w_pass_d      = r_pass;
    w_fail_d      = r_fail;
    w_fail_tn_d   = r_fail_tn;
`ifdef TEST_MON_TIMEOUT_EN
    w_timeout_d   = r_timeout;
`endif
    unique case (r_state)
      StIdle: w_state_d = StRun;
      StRun: begin
        if (r_cycle_cnt != '1) w_cycle_cnt_d = r_cycle_cnt + CNT_W'(1);
        if (w_done_wr) begin
          // A done write wins over a watchdog expiry on the same edge.
          w_state_d     = StDrain;
          w_drain_cnt_d = 8'(DRAIN_CYCLES);
        end
`ifdef TEST_MON_TIMEOUT_EN
        else if (w_wdog_hit) begin
          w_state_d     = StDone;
          w_cycle_cnt_d = r_cycle_cnt;
          w_done_d      = 1'b1;
          w_pass_d      = 1'b0;
          w_fail_d      = 1'b1;
          w_timeout_d   = 1'b1;
          w_fail_tn_d   = w_testnum_sh_d;
        end
`endif
      end
      StDrain: begin
        if (r_drain_cnt == 8'd0) begin
          w_state_d   = StDone;
          w_done_d    = 1'b1;
          w_pass_d    = (w_pass_sh_d == XLEN'(1));
          w_fail_d    = (w_pass_sh_d != XLEN'(1));
          w_fail_tn_d = w_testnum_sh_d;
        end else begin
          w_drain_cnt_d = r_drain_cnt - 8'd1;
        end
      end
      StDone: ;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_drain_cnt  <= '0;
      r_cycle_cnt  <= '0;
      r_testnum_sh <= '0;
      r_pass_sh    <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_tn    <= '0;
`ifdef TEST_MON_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_drain_cnt  <= w_drain_cnt_d;
      r_cycle_cnt  <= w_cycle_cnt_d;
      r_testnum_sh <= w_testnum_sh_d;
      r_pass_sh    <= w_pass_sh_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
      r_fail       <= w_fail_d;
      r_fail_tn    <= w_fail_tn_d;
`ifdef TEST_MON_TIMEOUT_EN
      r_timeout    <= w_timeout_d;
`endif
    end
  end

  assign done_o         = r_done;
  assign pass_o         = r_pass;
  assign fail_o         = r_fail;
  assign fail_testnum_o = r_fail_tn;
  assign cycle_cnt_o    = r_cycle_cnt;

endmodule
